reg_wb_queue: RTL and testbench
===============================

// Module: reg_wb_queue
// PURPOSE
//  Write-back queue directly upstream of the register file write port.
//  Accepts register write requests from two producers, ALU and load unit,
//  with valid/ready handshakes. Buffers them in program order and drains
//  one entry per cycle into wr_en/wr_reg_index/wr_reg_data.
//  Optional bypass lookup lets readers see writes still pending in the queue.
// PARAMETERS
//  REGISTER_WIDTH   32  data width; default from shared header
//  REG_INDEX_WIDTH  5   register index width; default from shared header
//  DEPTH            4   queue entries; power of two, >= 2
// PORTS
//  clk             in   1    clock; all state updates on rising edge
//  rst             in   1    reset; asynchronous, active-low
//  alu_wr_valid    in   1    ALU write request valid
//  alu_wr_index    in   RIW  ALU destination register
//  alu_wr_data     in   RW   ALU result
//  alu_wr_ready    out  1    queue can take the ALU request
//  ld_wr_valid     in   1    load write request valid
//  ld_wr_index     in   RIW  load destination register
//  ld_wr_data      in   RW   load data
//  ld_wr_ready     out  1    queue can take the load request
//  rd_reg_index_1  in   RIW  bypass lookup index, port 1
//  rd_reg_index_2  in   RIW  bypass lookup index, port 2
//  byp_hit_1/_2    out  1    a pending write exists for that index
//  byp_data_1/_2   out  RW   data of the youngest matching pending write
//  wr_en           out  1    register file write enable
//  wr_reg_index    out  RIW  register file write index
//  wr_reg_data     out  RW   register file write data
//  q_full          out  1    count == DEPTH
//  q_empty         out  1    count == 0
// BEHAVIOUR
//  - Reset (rst=0, async): count=0, pointers=0, entries invalid; wr_en=0,
//    wr_reg_index=0, wr_reg_data=0, q_empty=1, q_full=0, byp_hit_*=0,
//    byp_data_*=0. Reset mid-operation discards all queued writes.
//  - Transfer on a port only when valid && ready. A producer holds its request
//    stable until ready. free = DEPTH - count uses the registered count; a
//    same-cycle dequeue does not add space.
//  - alu_wr_ready = (free >= 1).
//    ld_wr_ready = alu_wr_valid ? (free >= 2) : (free >= 1).
//  - Ordering: if both ports transfer in one cycle, the load entry is enqueued
//    first (older instruction), then the ALU entry. Up to 2 enqueues/cycle.
//  - Index 0: a request whose index is 0 handshakes normally (ready rules
//    unchanged) but is not stored. It consumes no slot and never reaches wr_en.
//  - Drain: wr_en = !q_empty; wr_reg_index/data = head entry (driven directly
//    from storage, no extra latency). Head pops every cycle wr_en=1.
//    Latency: accepted request at edge N appears at head no earlier than N+1.
//  - Simultaneous enqueue(s) and dequeue: count_next = count + enq - deq.
//    Pointers wrap modulo DEPTH.
//  - Same index queued twice: both are written in order, so the youngest wins
//    in the register file.
// CONFIGURATION
//  WB_BYPASS_EN defined: byp_hit_k=1 iff rd_reg_index_k != 0 and a valid
//    entry matches, head included. byp_data_k = youngest match. Lookup is
//    combinational and excludes requests arriving this cycle.
//  WB_BYPASS_EN undefined: byp_hit_* = 0, byp_data_* = 0; no compare logic.
// STRUCTURE
//  - REGISTER_WIDTH and REG_INDEX_WIDTH come from the shared reg_file.h
//    header. Add a WB_QUEUE_DEPTH default there.
//  - Sub-module wb_bypass_lookup: youngest-match search over the entry
//    arrays. Instantiated twice under WB_BYPASS_EN.
// TESTING
//  1. Reset, then ALU write r5=1234 -> next cycle wr_en=1, idx 5, data 1234;
//     the cycle after, q_empty=1.
//  2. Same cycle: ld r3=77, alu r4=88 -> consecutive drains r3=77, then r4=88.
//  3. ALU r0=2431 -> alu_wr_ready=1, wr_en stays 0, q_empty stays 1.
//  4. With DEPTH=4, hold wr_en drain by filling in one cycle bursts: 3 stored,
//     then both ports valid -> alu_wr_ready=1, ld_wr_ready=0 until space.
//  5. WB_BYPASS_EN: queue r7=10 then r7=20, rd_reg_index_1=7 -> byp_hit_1=1,
//     byp_data_1=20. rd_reg_index_2=0 -> byp_hit_2=0.
//  6. Assert rst low with 3 entries queued -> wr_en=0 immediately; after
//     release, q_empty=1 and no stale writes appear.

Source files
------------

// File: rtl/reg_wb_queue_pkg.sv
// Shared register-file geometry and write-back queue defaults.
package reg_wb_queue_pkg;
    localparam int RF_REGISTER_WIDTH  = 32;
    localparam int RF_REG_INDEX_WIDTH = 5;
    localparam int WB_QUEUE_DEPTH     = 4;
endpackage

// File: rtl/reg_wb_queue_bypass_lookup.sv
// Youngest-match search over the pending write-back entries (built only with WB_BYPASS_EN).
`ifdef WB_BYPASS_EN
module wb_bypass_lookup
    import reg_wb_queue_pkg::*;
#(
    parameter int REGISTER_WIDTH  = RF_REGISTER_WIDTH,
    parameter int REG_INDEX_WIDTH = RF_REG_INDEX_WIDTH,
    parameter int DEPTH           = WB_QUEUE_DEPTH
) (
    input  logic [REG_INDEX_WIDTH-1:0] rd_index_i,
    input  logic [REG_INDEX_WIDTH-1:0] entry_idx_i  [DEPTH],
    input  logic [REGISTER_WIDTH-1:0]  entry_data_i [DEPTH],
    input  logic [DEPTH-1:0]           entry_vld_i,
    input  logic [$clog2(DEPTH)-1:0]   head_i,
    output logic                       hit_o,
    output logic [REGISTER_WIDTH-1:0]  data_o
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] slot;

    // Walk oldest to youngest so the last match seen is the youngest one.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        slot   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            slot = head_i + PTR_W'(k);
            if (rd_index_i != '0 && entry_vld_i[slot] && entry_idx_i[slot] == rd_index_i) begin
                hit_o  = 1'b1;
                data_o = entry_data_i[slot];
            end
        end
    end
endmodule
`endif

// File: rtl/reg_wb_queue.sv
// Write-back queue feeding the register file write port from ALU and load producers.
// Optional pending-write bypass lookup enabled by defining WB_BYPASS_EN.
module reg_wb_queue
    import reg_wb_queue_pkg::*;
#(
    parameter int REGISTER_WIDTH  = RF_REGISTER_WIDTH,
    parameter int REG_INDEX_WIDTH = RF_REG_INDEX_WIDTH,
    parameter int DEPTH           = WB_QUEUE_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       alu_wr_valid,
    input  logic [REG_INDEX_WIDTH-1:0] alu_wr_index,
    input  logic [REGISTER_WIDTH-1:0]  alu_wr_data,
    output logic                       alu_wr_ready,
    input  logic                       ld_wr_valid,
    input  logic [REG_INDEX_WIDTH-1:0] ld_wr_index,
    input  logic [REGISTER_WIDTH-1:0]  ld_wr_data,
    output logic                       ld_wr_ready,
    input  logic [REG_INDEX_WIDTH-1:0] rd_reg_index_1,
    input  logic [REG_INDEX_WIDTH-1:0] rd_reg_index_2,
    output logic                       byp_hit_1,
    output logic [REGISTER_WIDTH-1:0]  byp_data_1,
    output logic                       byp_hit_2,
    output logic [REGISTER_WIDTH-1:0]  byp_data_2,
    output logic                       wr_en,
    output logic [REG_INDEX_WIDTH-1:0] wr_reg_index,
    output logic [REGISTER_WIDTH-1:0]  wr_reg_data,
    output logic                       q_full,
    output logic                       q_empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [REG_INDEX_WIDTH-1:0] idx_q  [DEPTH];
    logic [REGISTER_WIDTH-1:0]  data_q [DEPTH];
    logic [DEPTH-1:0]           vld_q, vld_d;
    logic [PTR_W-1:0]           head_q, head_d, tail_q, tail_d;
    logic [PTR_W-1:0]           ld_slot, alu_slot;
    logic [CNT_W-1:0]           count_q, count_d, free;
    logic                       ld_store, alu_store, deq;

    // Space is judged on the registered count only; a same-cycle pop never frees a slot.
    assign free         = CNT_W'(DEPTH) - count_q;
    assign alu_wr_ready = (free >= CNT_W'(1));
    assign ld_wr_ready  = alu_wr_valid ? (free >= CNT_W'(2)) : (free >= CNT_W'(1));

    assign ld_store  = ld_wr_valid && ld_wr_ready && (ld_wr_index != '0);
    assign alu_store = alu_wr_valid && alu_wr_ready && (alu_wr_index != '0);
    assign deq       = (count_q != '0);

    // Load is the older instruction, so it takes the first free slot.
    always_comb begin
        ld_slot  = tail_q;
        alu_slot = tail_q + PTR_W'(ld_store);
        tail_d   = tail_q + PTR_W'(ld_store) + PTR_W'(alu_store);
        head_d   = head_q + PTR_W'(deq);
        count_d  = count_q + CNT_W'(ld_store) + CNT_W'(alu_store) - CNT_W'(deq);
        vld_d    = vld_q;
        if (deq) begin
            vld_d[head_q] = 1'b0;
        end
        if (ld_store) begin
            vld_d[ld_slot] = 1'b1;
        end
        if (alu_store) begin
            vld_d[alu_slot] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            vld_q   <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            vld_q   <= vld_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ld_store) begin
            idx_q[ld_slot]  <= ld_wr_index;
            data_q[ld_slot] <= ld_wr_data;
        end
        if (alu_store) begin
            idx_q[alu_slot]  <= alu_wr_index;
            data_q[alu_slot] <= alu_wr_data;
        end
    end

    // Head is presented straight from storage; gated so an empty queue shows zeros.
    assign wr_en        = deq;
    assign wr_reg_index = deq ? idx_q[head_q] : '0;
    assign wr_reg_data  = deq ? data_q[head_q] : '0;
    assign q_empty      = (count_q == '0);
    assign q_full       = (count_q == CNT_W'(DEPTH));

`ifdef WB_BYPASS_EN
    wb_bypass_lookup #(
        .REGISTER_WIDTH (REGISTER_WIDTH),
        .REG_INDEX_WIDTH(REG_INDEX_WIDTH),
        .DEPTH          (DEPTH)
    ) u_byp_1 (
        .rd_index_i  (rd_reg_index_1),
        .entry_idx_i (idx_q),
        .entry_data_i(data_q),
        .entry_vld_i (vld_q),
        .head_i      (head_q),
        .hit_o       (byp_hit_1),
        .data_o      (byp_data_1)
    );

    wb_bypass_lookup #(
        .REGISTER_WIDTH (REGISTER_WIDTH),
        .REG_INDEX_WIDTH(REG_INDEX_WIDTH),
        .DEPTH          (DEPTH)
    ) u_byp_2 (
        .rd_index_i  (rd_reg_index_2),
        .entry_idx_i (idx_q),
        .entry_data_i(data_q),
        .entry_vld_i (vld_q),
        .head_i      (head_q),
        .hit_o       (byp_hit_2),
        .data_o      (byp_data_2)
    );
`else
    logic unused_rd_index;
    assign unused_rd_index = ^{rd_reg_index_1, rd_reg_index_2};
    assign byp_hit_1  = 1'b0;
    assign byp_data_1 = '0;
    assign byp_hit_2  = 1'b0;
    assign byp_data_2 = '0;
`endif
endmodule

// File: tb/tb_reg_wb_queue.sv
// Self-checking bench for reg_wb_queue: directed table, corner sequences, randomized model check.
module tb_reg_wb_queue;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        alu_wr_valid = 1'b0, ld_wr_valid = 1'b0;
    logic [4:0]  alu_wr_index = '0, ld_wr_index = '0;
    logic [31:0] alu_wr_data = '0, ld_wr_data = '0;
    logic [4:0]  rd_reg_index_1 = '0, rd_reg_index_2 = '0;
    logic        alu_wr_ready, ld_wr_ready, byp_hit_1, byp_hit_2;
    logic [31:0] byp_data_1, byp_data_2, wr_reg_data;
    logic [4:0]  wr_reg_index;
    logic        wr_en, q_full, q_empty;

    // Second instance with DEPTH=2 so the full boundary is reachable.
    logic        s_alu_v = 1'b0, s_ld_v = 1'b0;
    logic [4:0]  s_alu_i = '0, s_ld_i = '0;
    logic [31:0] s_alu_d = '0, s_ld_d = '0;
    logic        s_alu_rdy, s_ld_rdy, s_hit1, s_hit2, s_wen, s_full, s_empty;
    logic [31:0] s_bd1, s_bd2, s_wdat;
    logic [4:0]  s_widx;

    always #5 clk = ~clk;

    reg_wb_queue #(.REGISTER_WIDTH(32), .REG_INDEX_WIDTH(5), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .alu_wr_valid(alu_wr_valid), .alu_wr_index(alu_wr_index), .alu_wr_data(alu_wr_data),
        .alu_wr_ready(alu_wr_ready),
        .ld_wr_valid(ld_wr_valid), .ld_wr_index(ld_wr_index), .ld_wr_data(ld_wr_data),
        .ld_wr_ready(ld_wr_ready),
        .rd_reg_index_1(rd_reg_index_1), .rd_reg_index_2(rd_reg_index_2),
        .byp_hit_1(byp_hit_1), .byp_data_1(byp_data_1),
        .byp_hit_2(byp_hit_2), .byp_data_2(byp_data_2),
        .wr_en(wr_en), .wr_reg_index(wr_reg_index), .wr_reg_data(wr_reg_data),
        .q_full(q_full), .q_empty(q_empty)
    );

    reg_wb_queue #(.REGISTER_WIDTH(32), .REG_INDEX_WIDTH(5), .DEPTH(2)) dut2 (
        .clk(clk), .rst(rst),
        .alu_wr_valid(s_alu_v), .alu_wr_index(s_alu_i), .alu_wr_data(s_alu_d),
        .alu_wr_ready(s_alu_rdy),
        .ld_wr_valid(s_ld_v), .ld_wr_index(s_ld_i), .ld_wr_data(s_ld_d),
        .ld_wr_ready(s_ld_rdy),
        .rd_reg_index_1(5'd0), .rd_reg_index_2(5'd0),
        .byp_hit_1(s_hit1), .byp_data_1(s_bd1),
        .byp_hit_2(s_hit2), .byp_data_2(s_bd2),
        .wr_en(s_wen), .wr_reg_index(s_widx), .wr_reg_data(s_wdat),
        .q_full(s_full), .q_empty(s_empty)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string nm, input int tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0d (0x%0h), expected %0d (0x%0h)", nm, tag, got, got, exp, exp);
        end
    endtask

    typedef struct {
        logic        av; logic [4:0] ai; logic [31:0] ad;
        logic        lv; logic [4:0] li; logic [31:0] ldat;
        logic        ardy; logic lrdy; logic wen; logic [4:0] widx; logic [31:0] wdat;
        logic        emp; logic full;
    } vec_t;
    vec_t vecs[$];

    task automatic add(input logic av, input logic [4:0] ai, input logic [31:0] ad,
                       input logic lv, input logic [4:0] li, input logic [31:0] ldat,
                       input logic ardy, input logic lrdy, input logic wen,
                       input logic [4:0] widx, input logic [31:0] wdat,
                       input logic emp, input logic full);
        vecs.push_back('{av, ai, ad, lv, li, ldat, ardy, lrdy, wen, widx, wdat, emp, full});
    endtask

    task automatic idle_inputs();
        alu_wr_valid = 1'b0; alu_wr_index = '0; alu_wr_data = '0;
        ld_wr_valid  = 1'b0; ld_wr_index  = '0; ld_wr_data  = '0;
    endtask

    typedef struct { logic [4:0] idx; logic [31:0] data; } ent_t;
    ent_t mq[$];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic alu_acc, ld_acc, e_ardy, e_lrdy, e_hit1, e_hit2;
        logic [31:0] e_bd1, e_bd2;
        int   free;

        // Reset state, sampled while reset is held.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst wr_en", 0, wr_en, 0);
        check("rst wr_idx", 0, wr_reg_index, 0);
        check("rst wr_data", 0, wr_reg_data, 0);
        check("rst q_empty", 0, q_empty, 1);
        check("rst q_full", 0, q_full, 0);
        check("rst byp_hit_1", 0, byp_hit_1, 0);
        check("rst byp_data_1", 0, byp_data_1, 0);
        @(posedge clk); #1 rst = 1'b1;

        // Directed table: single write, ordered pair, index 0, fill to free=1.
        add(0,0,0,     0,0,0,    1,1,0,0,0,1,0);
        add(1,5,1234,  0,0,0,    1,1,0,0,0,1,0);
        add(0,0,0,     0,0,0,    1,1,1,5,1234,0,0);
        add(0,0,0,     0,0,0,    1,1,0,0,0,1,0);
        add(1,4,88,    1,3,77,   1,1,0,0,0,1,0);
        add(0,0,0,     0,0,0,    1,1,1,3,77,0,0);
        add(0,0,0,     0,0,0,    1,1,1,4,88,0,0);
        add(0,0,0,     0,0,0,    1,1,0,0,0,1,0);
        add(1,0,2431,  0,0,0,    1,1,0,0,0,1,0);
        add(0,0,0,     0,0,0,    1,1,0,0,0,1,0);
        add(1,2,22,    1,1,11,   1,1,0,0,0,1,0);
        add(1,8,808,   1,6,66,   1,1,1,1,11,0,0);
        add(1,10,100,  1,9,99,   1,0,1,2,22,0,0);
        add(0,0,0,     1,9,99,   1,1,1,6,66,0,0);
        add(0,0,0,     0,0,0,    1,1,1,8,808,0,0);
        add(0,0,0,     0,0,0,    1,1,1,10,100,0,0);
        add(0,0,0,     0,0,0,    1,1,1,9,99,0,0);
        add(0,0,0,     0,0,0,    1,1,0,0,0,1,0);
        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk); #1;
            alu_wr_valid = vecs[i].av; alu_wr_index = vecs[i].ai; alu_wr_data = vecs[i].ad;
            ld_wr_valid  = vecs[i].lv; ld_wr_index  = vecs[i].li; ld_wr_data  = vecs[i].ldat;
            @(negedge clk);
            check("vec alu_rdy", i, alu_wr_ready, vecs[i].ardy);
            check("vec ld_rdy", i, ld_wr_ready, vecs[i].lrdy);
            check("vec wr_en", i, wr_en, vecs[i].wen);
            check("vec wr_idx", i, wr_reg_index, vecs[i].widx);
            check("vec wr_data", i, wr_reg_data, vecs[i].wdat);
            check("vec q_empty", i, q_empty, vecs[i].emp);
            check("vec q_full", i, q_full, vecs[i].full);
            check("vec byp_hit_1", i, byp_hit_1, 0);
        end
        @(posedge clk); #1 idle_inputs();

        // DEPTH=2 instance: two enqueues from empty fill it.
        @(posedge clk); #1;
        s_ld_v = 1; s_ld_i = 1; s_ld_d = 1; s_alu_v = 1; s_alu_i = 2; s_alu_d = 2;
        @(negedge clk);
        check("d2 alu_rdy", 0, s_alu_rdy, 1);
        check("d2 ld_rdy", 0, s_ld_rdy, 1);
        @(posedge clk); #1;
        s_ld_i = 3; s_ld_d = 3; s_alu_i = 4; s_alu_d = 4;
        @(negedge clk);
        check("d2 q_full", 1, s_full, 1);
        check("d2 alu_rdy", 1, s_alu_rdy, 0);
        check("d2 ld_rdy", 1, s_ld_rdy, 0);
        check("d2 wr_idx", 1, s_widx, 1);
        @(posedge clk); #1;
        @(negedge clk);
        check("d2 q_full", 2, s_full, 0);
        check("d2 alu_rdy", 2, s_alu_rdy, 1);
        check("d2 ld_rdy", 2, s_ld_rdy, 0);
        check("d2 wr_idx", 2, s_widx, 2);
        @(posedge clk); #1;
        s_alu_v = 0;
        @(negedge clk);
        check("d2 ld_rdy", 3, s_ld_rdy, 1);
        check("d2 wr_idx", 3, s_widx, 4);
        @(posedge clk); #1;
        s_ld_v = 0;
        @(negedge clk);
        check("d2 wr_data", 4, s_wdat, 3);
        @(posedge clk); #1;
        @(negedge clk);
        check("d2 q_empty", 5, s_empty, 1);
        check("d2 wr_en", 5, s_wen, 0);

`ifdef WB_BYPASS_EN
        // Bypass: two writes to r7, the ALU one is younger.
        @(posedge clk); #1;
        ld_wr_valid = 1; ld_wr_index = 7; ld_wr_data = 10;
        alu_wr_valid = 1; alu_wr_index = 7; alu_wr_data = 20;
        rd_reg_index_1 = 7; rd_reg_index_2 = 0;
        @(negedge clk);
        check("byp same-cycle hit_1", 0, byp_hit_1, 0);
        @(posedge clk); #1 idle_inputs();
        @(negedge clk);
        check("byp hit_1", 1, byp_hit_1, 1);
        check("byp data_1", 1, byp_data_1, 20);
        check("byp hit_2 r0", 1, byp_hit_2, 0);
        check("byp data_2 r0", 1, byp_data_2, 0);
        check("byp head data", 1, wr_reg_data, 10);
        @(posedge clk); #1 rd_reg_index_2 = 7;
        @(negedge clk);
        check("byp head-only hit_2", 2, byp_hit_2, 1);
        check("byp head-only data_2", 2, byp_data_2, 20);
        @(posedge clk); #1;
        @(negedge clk);
        check("byp drained hit_1", 3, byp_hit_1, 0);
        rd_reg_index_1 = 0; rd_reg_index_2 = 0;
`endif

        // Randomized traffic against a queue model.
        alu_acc = 1'b1; ld_acc = 1'b1;
        mq.delete();
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(posedge clk); #1;
            if (!alu_wr_valid || alu_acc) begin
                alu_wr_valid = ($urandom_range(0, 3) != 0);
                alu_wr_index = 5'($urandom_range(0, 7));
                alu_wr_data  = $urandom;
            end
            if (!ld_wr_valid || ld_acc) begin
                ld_wr_valid = ($urandom_range(0, 3) != 0);
                ld_wr_index = 5'($urandom_range(0, 7));
                ld_wr_data  = $urandom;
            end
            rd_reg_index_1 = 5'($urandom_range(0, 7));
            rd_reg_index_2 = 5'($urandom_range(0, 7));
            @(negedge clk);
            free   = DEPTH - mq.size();
            e_ardy = (free >= 1);
            e_lrdy = alu_wr_valid ? (free >= 2) : (free >= 1);
            e_hit1 = 0; e_bd1 = 0; e_hit2 = 0; e_bd2 = 0;
`ifdef WB_BYPASS_EN
            foreach (mq[k]) begin
                if (rd_reg_index_1 != 0 && mq[k].idx == rd_reg_index_1) begin e_hit1 = 1; e_bd1 = mq[k].data; end
                if (rd_reg_index_2 != 0 && mq[k].idx == rd_reg_index_2) begin e_hit2 = 1; e_bd2 = mq[k].data; end
            end
`endif
            check("rnd alu_rdy", cyc, alu_wr_ready, e_ardy);
            check("rnd ld_rdy", cyc, ld_wr_ready, e_lrdy);
            check("rnd wr_en", cyc, wr_en, mq.size() != 0);
            check("rnd wr_idx", cyc, wr_reg_index, mq.size() != 0 ? mq[0].idx : 5'd0);
            check("rnd wr_data", cyc, wr_reg_data, mq.size() != 0 ? mq[0].data : 32'd0);
            check("rnd q_full", cyc, q_full, mq.size() == DEPTH);
            check("rnd q_empty", cyc, q_empty, mq.size() == 0);
            check("rnd byp_hit_1", cyc, byp_hit_1, e_hit1);
            check("rnd byp_data_1", cyc, byp_data_1, e_bd1);
            check("rnd byp_hit_2", cyc, byp_hit_2, e_hit2);
            check("rnd byp_data_2", cyc, byp_data_2, e_bd2);
            alu_acc = alu_wr_valid && e_ardy;
            ld_acc  = ld_wr_valid && e_lrdy;
            if (mq.size() != 0) void'(mq.pop_front());
            if (ld_acc && ld_wr_index != 0) mq.push_back('{ld_wr_index, ld_wr_data});
            if (alu_acc && alu_wr_index != 0) mq.push_back('{alu_wr_index, alu_wr_data});
        end
        // Let the queue drain before the reset sequence.
        @(posedge clk); #1 idle_inputs(); rd_reg_index_1 = 0; rd_reg_index_2 = 0;
        repeat (DEPTH + 1) @(posedge clk);

        // Reset in mid-operation with three entries queued.
        #1;
        ld_wr_valid = 1; ld_wr_index = 1; ld_wr_data = 101;
        alu_wr_valid = 1; alu_wr_index = 2; alu_wr_data = 202;
        @(posedge clk); #1;
        ld_wr_index = 11; ld_wr_data = 111; alu_wr_index = 12; alu_wr_data = 212;
        @(posedge clk); #1 idle_inputs();
        @(negedge clk);
        check("pre-rst wr_idx", 0, wr_reg_index, 2);
        check("pre-rst q_empty", 0, q_empty, 0);
        #1 rst = 1'b0;
        #1;
        check("async rst wr_en", 0, wr_en, 0);
        check("async rst q_empty", 0, q_empty, 1);
        check("async rst wr_data", 0, wr_reg_data, 0);
        @(posedge clk); #1 rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post-rst wr_en", i, wr_en, 0);
            check("post-rst q_empty", i, q_empty, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
